// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: coefficient writer for the systolic FIR chain.
// Words arrive on a valid/ready stream into a shadow bank, one tap per
// beat. A complete set waits in PEND until the frame-boundary strobe
// swap_en, and then all taps move into the active bank on a single edge.
// Because of this, the MAC cells never see a half-updated coefficient set.
//
// Ports:
//   clk, clr       clock, async active-high reset
//   s_valid/s_ready/s_coeff/s_last   coefficient stream
//   swap_en        commit permitted (sampled only in PEND)
//   coeff_bus      active bank, tap i at [i*DIM_COEFF +: DIM_COEFF]
//   coeff_valid    sticky: a set has been committed since reset
//   load_done      one-cycle pulse on commit
//   load_err       one-cycle pulse on a framing error (short / missing last)

// One tap: a shadow register that is written from the stream, and an
// active register that is loaded from shadow on commit.
module fir_coeff_tap #(
  parameter int DIM_COEFF = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 wr_en_i,
  input  logic [DIM_COEFF-1:0] wr_data_i,
  input  logic                 commit_i,
  output logic [DIM_COEFF-1:0] act_o
);
  logic [DIM_COEFF-1:0] shadow_q, active_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en_i)  shadow_q <= wr_data_i;
      if (commit_i) active_q <= shadow_q;
    end
  end

  assign act_o = active_q;
endmodule

module fir_coeff_loader #(
  parameter int DIM_COEFF = 16,
  parameter int N_TAPS    = 8,
  parameter int CNT_W     = 3
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DIM_COEFF-1:0]        s_coeff,
  input  logic                        s_last,
  input  logic                        swap_en,
  output logic [N_TAPS*DIM_COEFF-1:0] coeff_bus,
  output logic                        coeff_valid,
  output logic                        load_done,
  output logic                        load_err
);
  typedef enum logic {LOAD = 1'b0, PEND = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cvalid_q;
  logic             commit;
  logic             accept;
  logic             last_tap;

  assign accept   = s_valid && s_ready;
  assign last_tap = (cnt_q == CNT_W'(N_TAPS - 1));

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (commit) cvalid_q <= 1'b1;
    end
  end

  // Next-state logic. Both framing errors reset the counter, so the next
  // beat always starts a fresh set at tap 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (last_tap) begin
            cnt_d = '0;
            if (s_last) state_d = PEND;
            else        err_d   = 1'b1;
          end else if (s_last) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PEND: begin
        if (swap_en) begin
          commit  = 1'b1;
          done_d  = 1'b1;
          state_d = LOAD;
        end
      end
    endcase
  end

  // Output decode
  always_comb begin
    s_ready     = (state_q == LOAD);
    coeff_valid = cvalid_q;
    load_done   = done_q;
    load_err    = err_q;
  end

  for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
    fir_coeff_tap #(.DIM_COEFF(DIM_COEFF)) u_tap (
      .clk       (clk),
      .clr       (clr),
      .wr_en_i   (accept && (cnt_q == CNT_W'(i))),
      .wr_data_i (s_coeff),
      .commit_i  (commit),
      .act_o     (coeff_bus[i*DIM_COEFF +: DIM_COEFF])
    );
  end
endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;
  localparam int DW = 16;
  localparam int NT = 8;
  localparam int CW = 3;
  localparam int BW = NT * DW;

  logic          clk = 1'b0;
  logic          clr, s_valid, s_last, swap_en;
  logic [DW-1:0] s_coeff;
  logic          s_ready, coeff_valid, load_done, load_err;
  logic [BW-1:0] coeff_bus;

  int n_chk  = 0;
  int n_pass = 0;

  fir_coeff_loader #(.DIM_COEFF(DW), .N_TAPS(NT), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .s_valid(s_valid), .s_ready(s_ready),
    .s_coeff(s_coeff), .s_last(s_last), .swap_en(swap_en),
    .coeff_bus(coeff_bus), .coeff_valid(coeff_valid),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Reference model: the words of the set in progress are held in a queue.
  // A set is good only if s_last arrives exactly on word NT.
  bit                   m_pend, m_cv, m_done, m_err;
  logic [DW-1:0]        m_words[$];
  logic [NT-1:0][DW-1:0] m_set, m_active;

  task automatic model_reset();
    m_pend = 0; m_cv = 0; m_done = 0; m_err = 0;
    m_words.delete();
    m_set = '0; m_active = '0;
  endtask

  task automatic model_edge(input bit v, input logic [DW-1:0] c, input bit l, input bit sw);
    m_done = 0; m_err = 0;
    if (m_pend) begin
      if (sw) begin
        m_active = m_set; m_cv = 1; m_done = 1; m_pend = 0;
      end
    end else if (v) begin
      m_words.push_back(c);
      if (l || m_words.size() == NT) begin
        if (l && m_words.size() == NT) begin
          for (int i = 0; i < NT; i++) m_set[i] = m_words[i];
          m_pend = 1;
        end else begin
          m_err = 1;
        end
        m_words.delete();
      end
    end
  endtask

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic compare_model();
    chk("s_ready",     BW'(s_ready),     BW'(!m_pend));
    chk("coeff_bus",   coeff_bus,        m_active);
    chk("coeff_valid", BW'(coeff_valid), BW'(m_cv));
    chk("load_done",   BW'(load_done),   BW'(m_done));
    chk("load_err",    BW'(load_err),    BW'(m_err));
    chk("done_err_excl", BW'(load_done && load_err), '0);
  endtask

  // Drive one cycle; inputs change 1 time unit after the edge, and outputs are sampled there too.
  task automatic step(input bit v, input logic [DW-1:0] c, input bit l, input bit sw);
    s_valid = v; s_coeff = c; s_last = l; swap_en = sw;
    @(posedge clk); #1;
    model_edge(v, c, l, sw);
    compare_model();
  endtask

  // Reset pulse between edges; checks that the outputs clear with no clock edge.
  task automatic async_reset(input string nm);
    #2 clr = 1'b1;
    #1;
    chk({nm, "_bus"},   coeff_bus,        '0);
    chk({nm, "_cv"},    BW'(coeff_valid), '0);
    chk({nm, "_ready"}, BW'(s_ready),     BW'(1));
    chk({nm, "_done"},  BW'(load_done),   '0);
    chk({nm, "_err"},   BW'(load_err),    '0);
    model_reset();
    #1 clr = 1'b0;
    s_valid = 0; s_last = 0; swap_en = 0; s_coeff = '0;
  endtask

  function automatic logic [BW-1:0] ramp(input int base);
    logic [NT-1:0][DW-1:0] r;
    for (int i = 0; i < NT; i++) r[i] = DW'(base + i);
    return r;
  endfunction

  typedef struct {
    bit rst; bit v; logic [DW-1:0] c; bit l; bit sw;
    bit rdy; bit done; bit err; bit cv; int bus_base;  // bus_base 0 => bus all zero
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit v, int c, bit l, bit sw,
                              bit rdy, bit done, bit err, bit cv, int bb);
    vec_t r;
    r.rst = rst; r.v = v; r.c = DW'(c); r.l = l; r.sw = sw;
    r.rdy = rdy; r.done = done; r.err = err; r.cv = cv; r.bus_base = bb;
    return r;
  endfunction

  initial begin
    logic [NT-1:0][DW-1:0] negs;
    logic [DW-1:0]         w;
    logic [BW-1:0]         exp_bus;
    bit                    v, l, sw;

    clr = 1'b1; s_valid = 0; s_last = 0; swap_en = 0; s_coeff = '0;
    model_reset();
    #3;
    chk("rst_bus",   coeff_bus,        '0);
    chk("rst_cv",    BW'(coeff_valid), '0);
    chk("rst_ready", BW'(s_ready),     BW'(1));
    chk("rst_done",  BW'(load_done),   '0);
    chk("rst_err",   BW'(load_err),    '0);
    #3 clr = 1'b0;

    // Table: gapless load 1..8 with swap two cycles later.
    for (int k = 1; k <= NT; k++) tbl.push_back(mk(0, 1, k, k == NT, 0, k < NT, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    // Table: short set of 3 after reset, then a full set 10..17 and a swap.
    tbl.push_back(mk(1, 1, 3, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 1, 0, 1, 0, 1, 0, 0));
    for (int k = 10; k <= 17; k++) tbl.push_back(mk(0, 1, k, k == 17, 0, k < 17, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 10));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) async_reset("tbl_rst");
      step(tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].sw);
      chk("tbl_ready", BW'(s_ready),     BW'(tbl[i].rdy));
      chk("tbl_done",  BW'(load_done),   BW'(tbl[i].done));
      chk("tbl_err",   BW'(load_err),    BW'(tbl[i].err));
      chk("tbl_cv",    BW'(coeff_valid), BW'(tbl[i].cv));
      chk("tbl_bus",   coeff_bus, (tbl[i].bus_base == 0) ? '0 : ramp(tbl[i].bus_base));
    end

    // Missing last: 8 words without s_last, then a swap that must be ignored.
    for (int k = 0; k < NT; k++) step(1, DW'(16'h100 + k), 0, 0);
    chk("miss_err",   BW'(load_err), BW'(1));
    chk("miss_ready", BW'(s_ready),  BW'(1));
    step(0, '0, 0, 1);
    chk("miss_swap_done", BW'(load_done), '0);
    chk("miss_bus",       coeff_bus,      ramp(10));

    // Backpressure: -1..-8 with random gaps, then a held word across PEND.
    async_reset("bp_rst");
    for (int k = 1; k <= NT; k++) begin
      while ($urandom_range(1, 0) == 1) step(0, DW'($urandom), 0, 0);
      w = DW'(-k);
      negs[k-1] = w;
      step(1, w, k == NT, 0);
    end
    for (int k = 0; k < 5; k++) begin
      step(1, 16'h55AA, 0, 0);
      chk("bp_held_ready", BW'(s_ready), '0);
    end
    step(1, 16'h55AA, 0, 1);
    exp_bus = negs;
    chk("bp_neg_bus", coeff_bus, exp_bus);
    step(1, 16'h55AA, 0, 0);
    for (int k = 1; k < NT; k++) step(1, DW'(16'h8000 + k), k == NT - 1, 0);
    step(0, '0, 0, 1);
    chk("bp_held_tap0", BW'(coeff_bus[DW-1:0]), BW'(16'h55AA));

    // Swap timing: swap_en during LOAD and on the final beat does nothing.
    async_reset("sw_rst");
    for (int k = 1; k <= NT; k++) step(1, DW'(16'h40 + k), k == NT, 1);
    chk("sw_final_done", BW'(load_done), '0);
    chk("sw_final_bus",  coeff_bus,      '0);
    step(0, '0, 0, 1);
    chk("sw_commit_bus", coeff_bus, ramp(16'h41));
    step(0, '0, 0, 1);
    chk("sw_one_done", BW'(load_done), '0);

    // Async reset mid-set and in PEND after a prior commit.
    async_reset("ar0");
    for (int k = 1; k <= 4; k++) step(1, DW'(k), 0, 0);
    async_reset("ar_midset");
    for (int k = 1; k <= NT; k++) step(1, DW'(k), k == NT, 0);
    step(0, '0, 0, 1);
    for (int k = 1; k <= NT; k++) step(1, DW'(k + 50), k == NT, 0);
    chk("ar_pend_ready", BW'(s_ready), '0);
    async_reset("ar_pend");
    for (int k = 1; k <= NT; k++) step(1, DW'(k), k == NT, 0);
    chk("ar_reload_ready", BW'(s_ready), '0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    chk("ar_reload_bus", coeff_bus, ramp(1));

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(9, 0) < 7);
      l  = (m_words.size() == NT - 1) ? ($urandom_range(9, 0) < 8) : ($urandom_range(19, 0) == 0);
      sw = ($urandom_range(2, 0) == 0);
      step(v, DW'($urandom), l, sw);
      if ($urandom_range(199, 0) == 0) async_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
